// File: rtl/core_pkg.sv
// Shared types for the data-SRAM arbiter: FSM states, SRAM request bundle.
package core_pkg;

    localparam int DAT_AW = 16;

    typedef enum logic [1:0] {
        PRI_M0,
        PRI_M1,
        LOCK_M1
    } arb_st_e;

    typedef struct packed {
        logic [DAT_AW-1:0] a;
        logic [3:0]        we;
        logic [31:0]       wd;
        logic [3:0]        re;
    } sram_req_t;

endpackage

// File: rtl/u_dsram_arb.sv
// Two-master arbiter for the single-port data SRAM: core (m0) has fixed
// priority, the host port (m1) is promoted after STARVE_LIM lost cycles and
// may lock the port for read-modify-write. Read data is steered back to the
// master that issued the read one cycle earlier.
module u_dsram_arb
    import core_pkg::*;
#(
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = $clog2(STARVE_LIM + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [DAT_AW-1:0] m0_a,
    input  logic [3:0]        m0_we,
    input  logic [31:0]       m0_wd,
    input  logic [3:0]        m0_re,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rd,
    input  logic              m1_req,
    input  logic [DAT_AW-1:0] m1_a,
    input  logic [3:0]        m1_we,
    input  logic [31:0]       m1_wd,
    input  logic [3:0]        m1_re,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rd,
    input  logic              m1_lock,
    output logic [DAT_AW-1:0] dat_a,
    output logic [3:0]        dat_we,
    output logic [31:0]       dat_wd,
    output logic [3:0]        dat_re,
    input  logic [31:0]       dat_rd
);

    arb_st_e          r_st;
    arb_st_e          w_st_nxt;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] w_wcnt_nxt;
    logic             r_rd_pend;
    logic             r_rd_own;
    sram_req_t        w_m0;
    sram_req_t        w_m1;
    sram_req_t        w_sel;
    logic             w_rd_issue;

    assign w_m0 = '{a: m0_a, we: m0_we, wd: m0_wd, re: m0_re};
    assign w_m1 = '{a: m1_a, we: m1_we, wd: m1_wd, re: m1_re};

    // Grant selection: PRI_M0 favours the core, PRI_M1/LOCK_M1 favour the host.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (r_st == PRI_M0) begin
                if (m0_req)      m0_gnt = 1'b1;
                else if (m1_req) m1_gnt = 1'b1;
            end else begin
                if (m1_req)      m1_gnt = 1'b1;
                else if (m0_req) m0_gnt = 1'b1;
            end
        end
    end

    // SRAM request mux; a write suppresses any read enables in the same request.
    always_comb begin
        w_sel = '0;
        if (m1_gnt)      w_sel = w_m1;
        else if (m0_gnt) w_sel = w_m0;
        if (w_sel.we != '0) w_sel.re = '0;
    end

    assign dat_a      = w_sel.a;
    assign dat_we     = w_sel.we;
    assign dat_wd     = w_sel.wd;
    assign dat_re     = w_sel.re;
    assign w_rd_issue = (dat_re != '0);

    // Next-state and starvation-counter logic.
    always_comb begin
        w_st_nxt   = r_st;
        w_wcnt_nxt = r_wcnt;
        if (m1_gnt || !m1_req)
            w_wcnt_nxt = '0;
        else if (r_wcnt != CNT_W'(STARVE_LIM))
            w_wcnt_nxt = r_wcnt + 1'b1;
        unique case (r_st)
            PRI_M0: begin
                if (m1_gnt && m1_lock)
                    w_st_nxt = LOCK_M1;
                else if (m1_req && !m1_gnt && r_wcnt == CNT_W'(STARVE_LIM - 1))
                    w_st_nxt = PRI_M1;
            end
            PRI_M1: begin
                if (m1_gnt && m1_lock)
                    w_st_nxt = LOCK_M1;
                else if (m1_gnt || !m1_req)
                    w_st_nxt = PRI_M0;
            end
            LOCK_M1: begin
                if (!m1_lock)
                    w_st_nxt = PRI_M0;
            end
            default: w_st_nxt = PRI_M0;
        endcase
    end

    // State, counter and read-ownership registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st      <= PRI_M0;
            r_wcnt    <= '0;
            r_rd_pend <= 1'b0;
            r_rd_own  <= 1'b0;
        end else begin
            r_st      <= w_st_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_rd_pend <= w_rd_issue;
            r_rd_own  <= m1_gnt;
        end
    end

    // Read return steering; masked during reset so an in-flight read is dropped.
    always_comb begin
        m0_rvalid = r_rd_pend && !r_rd_own && !rst;
        m1_rvalid = r_rd_pend &&  r_rd_own && !rst;
        m0_rd     = m0_rvalid ? dat_rd : '0;
        m1_rd     = m1_rvalid ? dat_rd : '0;
    end

endmodule

// File: tb/tb_u_dsram_arb.sv
// Directed bench for u_dsram_arb with a behavioural one-cycle SRAM.
module tb_u_dsram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m1_lock;
    logic [15:0] m0_a, m1_a;
    logic [3:0]  m0_we, m0_re, m1_we, m1_re;
    logic [31:0] m0_wd, m1_wd;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rd, m1_rd;
    logic [15:0] dat_a;
    logic [3:0]  dat_we, dat_re;
    logic [31:0] dat_wd, dat_rd;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    u_dsram_arb #(.STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_a(m0_a), .m0_we(m0_we), .m0_wd(m0_wd), .m0_re(m0_re),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_a(m1_a), .m1_we(m1_we), .m1_wd(m1_wd), .m1_re(m1_re),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
        .m1_lock(m1_lock),
        .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re),
        .dat_rd(dat_rd)
    );

    // Single-port SRAM model: byte writes, registered read data.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (dat_we[b]) mem[dat_a[7:0]][8*b +: 8] = dat_wd[8*b +: 8];
        if (dat_re != 4'h0) dat_rd <= mem[dat_a[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle's input-drive point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_a = '0; m0_we = '0; m0_wd = '0; m0_re = '0;
        m1_req = 0; m1_a = '0; m1_we = '0; m1_wd = '0; m1_re = '0;
        m1_lock = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h01] = 32'h11111111;
        mem[8'h02] = 32'h22222222;
        dat_rd = '0;
        idle();
        rst = 1;
        m0_req = 1; m0_re = 4'hF; m1_req = 1;
        @(negedge clk);
        chk("rst_m0_gnt", {31'b0, m0_gnt}, 0);
        chk("rst_m1_gnt", {31'b0, m1_gnt}, 0);
        chk("rst_dat_re", {28'b0, dat_re}, 0);
        chk("rst_dat_a",  {16'b0, dat_a}, 0);
        step();
        idle();
        step();
        rst = 0;
        step();

        // Core-only read.
        m0_req = 1; m0_a = 16'h0010; m0_re = 4'hF;
        @(negedge clk);
        chk("rd_m0_gnt",  {31'b0, m0_gnt}, 1);
        chk("rd_m1_gnt",  {31'b0, m1_gnt}, 0);
        chk("rd_dat_re",  {28'b0, dat_re}, 32'hF);
        chk("rd_dat_a",   {16'b0, dat_a}, 32'h10);
        step();
        idle();
        @(negedge clk);
        chk("rd_m0_rvalid", {31'b0, m0_rvalid}, 1);
        chk("rd_m0_rd",     m0_rd, 32'hDEADBEEF);
        chk("rd_m1_rvalid", {31'b0, m1_rvalid}, 0);
        chk("rd_m1_rd",     m1_rd, 0);
        chk("idle_dat_a",   {16'b0, dat_a}, 0);
        step();

        // Continuous contention: m1 wins every 5th cycle.
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk($sformatf("cont_m0_gnt[%0d]", i), {31'b0, m0_gnt}, (i % 5 != 4) ? 1 : 0);
            chk($sformatf("cont_m1_gnt[%0d]", i), {31'b0, m1_gnt}, (i % 5 == 4) ? 1 : 0);
            step();
        end
        idle();
        step();

        // Lock: m1 holds the port for 6 cycles against m0.
        m1_req = 1; m1_lock = 1;
        @(negedge clk);
        chk("lock_take", {31'b0, m1_gnt}, 1);
        step();
        m0_req = 1;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) m1_lock = 0;
            @(negedge clk);
            chk($sformatf("lock_m1_gnt[%0d]", i), {31'b0, m1_gnt}, 1);
            chk($sformatf("lock_m0_gnt[%0d]", i), {31'b0, m0_gnt}, 0);
            step();
        end
        @(negedge clk);
        chk("unlock_m0_gnt", {31'b0, m0_gnt}, 1);
        chk("unlock_m1_gnt", {31'b0, m1_gnt}, 0);
        step();
        idle();
        step();

        // Write wins over read in the same request.
        m0_req = 1; m0_a = 16'h0020; m0_we = 4'b0011; m0_re = 4'hF; m0_wd = 32'h12345678;
        @(negedge clk);
        chk("wr_dat_we", {28'b0, dat_we}, 32'h3);
        chk("wr_dat_re", {28'b0, dat_re}, 0);
        chk("wr_dat_wd", dat_wd, 32'h12345678);
        step();
        idle();
        @(negedge clk);
        chk("wr_no_rvalid", {31'b0, m0_rvalid}, 0);
        step();
        m0_req = 1; m0_a = 16'h0020; m0_re = 4'hF;
        step();
        idle();
        @(negedge clk);
        chk("wr_readback", m0_rd, 32'h00005678);
        step();

        // Back-to-back reads from different masters.
        m0_req = 1; m0_a = 16'h0001; m0_re = 4'hF;
        step();
        idle();
        m1_req = 1; m1_a = 16'h0002; m1_re = 4'hF;
        @(negedge clk);
        chk("b2b_m1_gnt",    {31'b0, m1_gnt}, 1);
        chk("b2b_m0_rvalid", {31'b0, m0_rvalid}, 1);
        chk("b2b_m0_rd",     m0_rd, 32'h11111111);
        chk("b2b_m1_rv_c1",  {31'b0, m1_rvalid}, 0);
        step();
        idle();
        @(negedge clk);
        chk("b2b_m1_rvalid", {31'b0, m1_rvalid}, 1);
        chk("b2b_m1_rd",     m1_rd, 32'h22222222);
        chk("b2b_m0_rv_c2",  {31'b0, m0_rvalid}, 0);
        chk("b2b_m0_rd_c2",  m0_rd, 0);
        step();

        // Starve m1 into PRI_M1 while m0 reads, then reset mid-read.
        m0_req = 1; m0_a = 16'h0010; m0_re = 4'hF; m1_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("pre_rst_m0_gnt[%0d]", i), {31'b0, m0_gnt}, 1);
            step();
        end
        rst = 1;
        @(negedge clk);
        chk("mid_rst_m0_rvalid", {31'b0, m0_rvalid}, 0);
        chk("mid_rst_m0_rd",     m0_rd, 0);
        chk("mid_rst_m1_gnt",    {31'b0, m1_gnt}, 0);
        chk("mid_rst_dat_re",    {28'b0, dat_re}, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("post_rst_m0_gnt",    {31'b0, m0_gnt}, 1);
        chk("post_rst_m1_gnt",    {31'b0, m1_gnt}, 0);
        chk("post_rst_m0_rvalid", {31'b0, m0_rvalid}, 0);
        step();
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/u_dsram_arb.md
Name: u_dsram_arb

Overview:
- Two-requester arbiter sharing the single-port data SRAM (sram1) between the core load/store path (m0) and a host/loader DMA port (m1).
- Core has fixed priority. A starvation counter promotes m1 after a bounded wait, and m1 may lock the port for read-modify-write sequences.
- It also routes the one-cycle-latency SRAM read data back to the requester that issued the read.
- Sits between core's dat_* port and the sram1 macro.

Parameters:
- STARVE_LIM, 4, consecutive cycles m1 may wait before it gains priority; legal range >= 1.
- CNT_W, $clog2(STARVE_LIM+1), starvation counter width; derived, not overridden.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  core access request, held until granted
- m0_a  in  16  core word address
- m0_we  in  4  core byte write enables
- m0_wd  in  32  core write data
- m0_re  in  4  core byte read enables
- m0_gnt  out  1  core request accepted this cycle
- m0_rvalid  out  1  core read data valid
- m0_rd  out  32  core read data
- m1_req, m1_a, m1_we, m1_wd, m1_re, m1_gnt, m1_rvalid, m1_rd: same widths and meanings as m0, for the host port
- m1_lock  in  1  host requests exclusive priority while high
- dat_a  out  16  SRAM address
- dat_we  out  4  SRAM byte write enables
- dat_wd  out  32  SRAM write data
- dat_re  out  4  SRAM byte read enables
- dat_rd  in  32  SRAM read data, valid cycle after dat_re != 0

Behaviour:
- Grants are combinational from current state and reqs; at most one gnt per cycle. A request is accepted in the cycle req&gnt.
- SRAM outputs (dat_a/we/wd/re) mux the granted master's fields. With no grant, all four outputs = 0.
- If we != 0 and re != 0 in the same request, the write wins; dat_re is forced to 0 and no rvalid is generated.
- A granted request with we=0 and re=0 consumes the slot; no SRAM access, no rvalid.
- Read return: register rd_pend and rd_own on a granted read. mX_rvalid = rd_pend & (rd_own==X), exactly 1 cycle after grant. mX_rd = dat_rd when mX_rvalid, else 0.
- Back-to-back reads on consecutive cycles are supported, one per cycle, with no bubbles.
- FSM states: PRI_M0, PRI_M1, LOCK_M1.
  - PRI_M0: gnt to m0 if m0_req, else m1 if m1_req.
  - PRI_M1 and LOCK_M1: gnt to m1 if m1_req, else m0 if m0_req.
- Starvation counter wcnt:
  - Clears on m1 grant or when m1_req=0.
  - Otherwise increments, saturating at STARVE_LIM.
- Transitions:
  - PRI_M0 -> PRI_M1 when m1_req & !m1_gnt & wcnt==STARVE_LIM-1, i.e. on the STARVE_LIM-th lost cycle.
  - PRI_M0 or PRI_M1 -> LOCK_M1 when m1_gnt & m1_lock.
  - PRI_M1 -> PRI_M0 when m1_gnt & !m1_lock, or when m1_req=0.
  - LOCK_M1 -> PRI_M0 when m1_lock=0; the current cycle still uses LOCK_M1 priority.
- m1_lock is ignored unless m1 is granted in PRI_M0 or PRI_M1.
- Simultaneous m0_req and m1_req in PRI_M0 with wcnt < STARVE_LIM-1: m0 wins and wcnt increments.
- Reset (including mid-read): state = PRI_M0, wcnt = 0, rd_pend = 0. All gnt, rvalid, rd and dat_* outputs are 0 while rst is high. A read granted in the cycle before rst asserts produces no rvalid.
- Requests are not internally queued; a master whose req drops before gnt is simply not served.

Decomposition:
- Shared package core_pkg holds:
  - typedef arb_st_e {PRI_M0, PRI_M1, LOCK_M1}.
  - typedef struct sram_req_t {a, we, wd, re}.
  - Localparam DAT_AW=16.
- No sub-module; single flat module of roughly 150 lines.

Test Plan:
- Core only: m0 read at a=0x0010 (memory 0xDEADBEEF), re=4'hF -> m0_gnt same cycle, dat_re=4'hF, m0_rvalid next cycle with m0_rd=0xDEADBEEF, m1_rvalid=0.
- Contention, STARVE_LIM=4: m0_req and m1_req high continuously -> m0 granted cycles 0-3, m1 granted cycle 4, m0 granted cycle 5, then m1 again at cycle 9; repeat period 5.
- Lock: m1 granted with m1_lock=1, then m1_req held 6 cycles with m0_req high -> m1_gnt for all 6. m1_lock drops in cycle 6 -> m0 granted cycle 7.
- Write-over-read: m0 request we=4'b0011, re=4'hF, wd=0x12345678 -> dat_we=4'b0011, dat_re=0, no m0_rvalid.
- Back-to-back: m0 read 0x0001, then m1 read 0x0002 in the next cycle -> m0_rvalid in cycle 1 and m1_rvalid in cycle 2, each with the correct data and no crossover.
- Reset mid-read: granted read in cycle N, rst high in cycle N+1 -> no rvalid. After reset, state is PRI_M0, so simultaneous requests in the first cycle go to m0.
